// File: rtl/fetch_pkg.sv
// Fetch-stage shared types: prediction metadata carried with each request
// and the entry handed to decode.
package fetch_pkg;

  localparam int INSTR_W          = 32;
  localparam int FETCH_XLEN       = 32;
  localparam int FETCH_PRED_DEPTH = 64;
  localparam int FETCH_IW         = $clog2(FETCH_PRED_DEPTH);

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic                  pred_taken;
    logic [FETCH_XLEN-1:0] pred_target;
    logic [FETCH_IW-1:0]   pred_index;
  } fetch_meta_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    fetch_meta_t        meta;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory, branch predictor query,
// backend redirect and the decode-side valid/ready channel.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IW   = 6
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic [XLEN-1:0]    bpu_addr;
  logic               bpu_taken;
  logic [XLEN-1:0]    bpu_target;
  logic [IW-1:0]      bpu_index;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               out_pred_taken;
  logic [XLEN-1:0]    out_pred_target;
  logic [IW-1:0]      out_pred_index;

  modport master (
    output imem_req_valid, imem_addr, bpu_addr,
           out_valid, out_instr, out_pc, out_pred_taken, out_pred_target, out_pred_index,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           bpu_taken, bpu_target, bpu_index,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, bpu_addr,
           out_valid, out_instr, out_pc, out_pred_taken, out_pred_target, out_pred_index,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           bpu_taken, bpu_target, bpu_index,
           redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count. The head output reads
// as zero while empty so downstream ports idle at 0.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers/count; a clear wins over any push or pop in that cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clock) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word requests,
// follows the combinational predictor, buffers responses with their
// prediction metadata for decode, and handles backend redirects by
// flushing and discarding stale in-flight responses.
// Optional build macro FETCH_PERF_EN adds perf_redirects/perf_discards.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              PREDITOR_DEPTH = 64,
  parameter int              FIFO_DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic          clock,
  input  logic          resetn,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_redirects,
  output logic [31:0]   perf_discards
`endif
);

  localparam int IW = $clog2(PREDITOR_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  // The buffered structs are sized from fetch_pkg; reject mismatched builds.
  if (XLEN != FETCH_XLEN || IW != FETCH_IW) begin : g_param_check
    $error("fetch_stage: XLEN/PREDITOR_DEPTH must match fetch_pkg widths");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            run_q;

  logic            redirect, credit_ok, req_fire;
  logic            resp_keep, resp_drop, out_fire;
  fetch_meta_t     meta_in, meta_head;
  fetch_entry_t    entry_in, entry_head;
  logic            meta_empty, meta_full, out_empty, out_full;
  logic [CW-1:0]   meta_count, out_count;

  assign redirect  = bus.redirect_valid;
  // Every accepted request owns an output slot, so responses never stall.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, out_count}) < CREDITS;
  assign bus.imem_req_valid = run_q && !redirect && credit_ok;
  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_drop = bus.imem_resp_valid && (redirect || discard_q != '0);
  assign resp_keep = bus.imem_resp_valid && !redirect && discard_q == '0;
  assign out_fire  = bus.out_valid && bus.out_ready;

  assign bus.imem_addr = pc_q;
  assign bus.bpu_addr  = pc_q;

  // Metadata captured at request time and the entry formed on response.
  always_comb begin
    meta_in.pc          = pc_q;
    meta_in.pred_taken  = bus.bpu_taken;
    meta_in.pred_target = bus.bpu_target;
    meta_in.pred_index  = bus.bpu_index;
    entry_in.instr      = bus.imem_resp_data;
    entry_in.meta       = meta_head;
  end

  // Next PC, outstanding-request and stale-response bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
    if (req_fire) pc_d = bus.bpu_taken ? bus.bpu_target : pc_q + XLEN'(4);
    if (bus.imem_resp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
    if (redirect) begin
      pc_d      = bus.redirect_pc;
      // Every response still outstanding after this cycle is stale,
      // including those already marked by an earlier redirect.
      discard_d = inflight_q - CW'(bus.imem_resp_valid);
    end
  end

  // Control registers; run_q holds off requests while reset is asserted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_meta_t)), .DEPTH(FIFO_DEPTH)) u_meta_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (redirect),
    .push_i  (req_fire),
    .data_i  (meta_in),
    .pop_i   (resp_keep),
    .data_o  (meta_head),
    .empty_o (meta_empty),
    .full_o  (meta_full),
    .count_o (meta_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (redirect),
    .push_i  (resp_keep),
    .data_i  (entry_in),
    .pop_i   (out_fire),
    .data_o  (entry_head),
    .empty_o (out_empty),
    .full_o  (out_full),
    .count_o (out_count)
  );

  assign bus.out_valid       = !out_empty;
  assign bus.out_instr       = entry_head.instr;
  assign bus.out_pc          = entry_head.meta.pc;
  assign bus.out_pred_taken  = entry_head.meta.pred_taken;
  assign bus.out_pred_target = entry_head.meta.pred_target;
  assign bus.out_pred_index  = entry_head.meta.pred_index;

  logic unused_fifo;
  assign unused_fifo = &{1'b0, meta_full, meta_count};

  // A kept response must find its request metadata waiting.
  assert property (@(posedge clock) disable iff (!resetn) resp_keep |-> !meta_empty);
  // The credit rule keeps the output queue from overflowing.
  assert property (@(posedge clock) disable iff (!resetn) resp_keep |-> !out_full);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects_q, perf_discards_q;

  // Saturating counters of redirect cycles and dropped responses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_redirects_q <= '0;
      perf_discards_q  <= '0;
    end else begin
      if (redirect && perf_redirects_q != '1) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (resp_drop && perf_discards_q != '1) perf_discards_q <= perf_discards_q + 32'd1;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_discards  = perf_discards_q;
`else
  logic unused_perf;
  assign unused_perf = resp_drop;
`endif

endmodule
